// File: rtl/fetch_branch_unit.sv
// Program-counter / branch stage: latches ALU overflow into a flag and resolves BNO/BOF via an 8-entry jump table.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module fetch_branch_unit #(
  parameter int unsigned PC_W = 10
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            lut_we,
  input  logic [2:0]      lut_addr,
  input  logic [PC_W-1:0] lut_data,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic [2:0]      opcode,
  input  logic [2:0]      funcA,
  input  logic            funcB,
  input  logic            alu_overflow,
  output logic [PC_W-1:0] pc,
  output logic            flag,
  output logic            running,
  output logic            done
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0]      taken_cnt
`endif
);

  localparam int unsigned LUT_DEPTH = 8;
  localparam logic [2:0]  OP_BRANCH = 3'b111;
  localparam logic [2:0]  OP_HALT   = 3'b110;
  localparam logic [2:0]  FA_HALT   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            flag_nxt;
  logic            accept;
  logic            is_halt;
  logic            is_branch;
  logic            taken;
  logic            tbl_we;
  logic            restart;
  logic [PC_W-1:0] jump_table [LUT_DEPTH];

`ifdef BRANCH_STATS_EN
  logic [7:0] cnt_nxt;
`endif

  assign accept    = (state == S_RUN) && instr_valid && !stall;
  assign is_halt   = (opcode == OP_HALT) && (funcA == FA_HALT) && funcB;
  assign is_branch = (opcode == OP_BRANCH);
  assign tbl_we    = lut_we && (state == S_IDLE);
  assign restart   = start && (state != S_RUN);

  // Next-state, PC and flag selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flag_nxt  = flag;
    taken     = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          flag_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (is_halt) begin
            state_nxt = S_HALT;
          end else if (is_branch) begin
            // Resolved against the registered flag; a branch never writes the flag.
            taken  = funcB ? flag : ~flag;
            pc_nxt = taken ? jump_table[funcA] : pc + PC_W'(1);
          end else begin
            flag_nxt = alu_overflow;
            pc_nxt   = pc + PC_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      flag    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      flag    <= flag_nxt;
      running <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_HALT);
    end
  end

  // Jump table: written only while idle, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        jump_table[i] <= '0;
      end
    end else if (tbl_we) begin
      jump_table[lut_addr] <= lut_data;
    end
  end

`ifdef BRANCH_STATS_EN
  always_comb begin
    cnt_nxt = taken_cnt;
    if (restart) begin
      cnt_nxt = 8'h00;
    end else if (taken && (taken_cnt != 8'hFF)) begin
      cnt_nxt = taken_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= 8'h00;
    end else begin
      taken_cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Scoreboard bench for fetch_branch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_branch_unit;

  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic            clock;
  logic            reset_n;
  logic            start;
  logic            lut_we;
  logic [2:0]      lut_addr;
  logic [PC_W-1:0] lut_data;
  logic            instr_valid;
  logic            stall;
  logic [2:0]      opcode;
  logic [2:0]      funcA;
  logic            funcB;
  logic            alu_overflow;
  logic [PC_W-1:0] pc;
  logic            flag;
  logic            running;
  logic            done;
`ifdef BRANCH_STATS_EN
  logic [7:0]      taken_cnt;
`endif

  fetch_branch_unit #(.PC_W(PC_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .lut_we       (lut_we),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .opcode       (opcode),
    .funcA        (funcA),
    .funcB        (funcB),
    .alu_overflow (alu_overflow),
    .pc           (pc),
    .flag         (flag),
    .running      (running),
    .done         (done)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int pc;
    bit flag;
    bit running;
    bit done;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0=idle, 1=run, 2=halted.
  int m_mode;
  int m_pc;
  bit m_flag;
  int m_cnt;
  int m_table [8];

  function automatic void model_reset();
    m_mode = 0; m_pc = 0; m_flag = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) m_table[i] = 0;
  endfunction

  function automatic void model_step(bit st, bit we, int addr, int data, bit v, bit s,
                                     int op, int fa, bit fb, bit ov);
    bit tk;
    if (m_mode == 0 && we) m_table[addr] = data;
    if (st && m_mode != 1) begin
      m_mode = 1; m_pc = 0; m_flag = 0; m_cnt = 0;
    end else if (m_mode == 1 && v && !s) begin
      if (op == 6 && fa == 7 && fb) begin
        m_mode = 2;
      end else if (op == 7) begin
        tk = fb ? m_flag : !m_flag;
        if (tk) begin
          m_pc  = m_table[fa];
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end else begin
        m_flag = ov;
        m_pc   = (m_pc + 1) % PC_MOD;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the post-edge expectation.
  task automatic cyc(input bit st, input bit we, input int addr, input int data,
                     input bit v, input bit s, input int op, input int fa,
                     input bit fb, input bit ov);
    exp_t e;
    start = st; lut_we = we; lut_addr = 3'(addr); lut_data = PC_W'(data);
    instr_valid = v; stall = s; opcode = 3'(op); funcA = 3'(fa); funcB = fb;
    alu_overflow = ov;
    model_step(st, we, addr, data, v, s, op, fa, fb, ov);
    e.pc = m_pc; e.flag = m_flag; e.running = (m_mode == 1);
    e.done = (m_mode == 2); e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic instr(input int op, input int fa, input bit fb, input bit ov);
    cyc(0, 0, 0, 0, 1, 0, op, fa, fb, ov);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, int'(pc), 0);
    check({tag, "_flag"}, int'(flag), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_done"}, int'(done), 0);
`ifdef BRANCH_STATS_EN
    check({tag, "_cnt"}, int'(taken_cnt), 0);
`endif
  endtask

  // Monitor: after every rising edge compare registered outputs to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", int'(pc), e.pc);
        check("sb_flag", int'(flag), int'(e.flag));
        check("sb_running", int'(running), int'(e.running));
        check("sb_done", int'(done), int'(e.done));
        check("sb_excl", int'(running & done), 0);
`ifdef BRANCH_STATS_EN
        check("sb_cnt", int'(taken_cnt), e.cnt);
`endif
      end
    end
  end

  initial begin
    int st_r;
    int v_r;
    int op_r;
    reset_n = 1'b0;
    start = 0; lut_we = 0; lut_addr = '0; lut_data = '0; instr_valid = 0;
    stall = 0; opcode = '0; funcA = '0; funcB = 0; alu_overflow = 0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table load in IDLE, then start.
    cyc(0, 1, 2, 40, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 100, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 1023, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s1_running", int'(running), 1);

    // Three ADDs, then overflow-setting MATCH and branches.
    repeat (3) instr(0, 0, 0, 0);
    check("s2_pc", int'(pc), 3);
    instr(5, 0, 0, 1);
    instr(7, 2, 1, 0);
    check("s3_bof_pc", int'(pc), 40);
    check("s3_flag", int'(flag), 1);
`ifdef BRANCH_STATS_EN
    check("s3_cnt", int'(taken_cnt), 1);
`endif
    instr(7, 2, 0, 0);
    check("s3_bno_pc", int'(pc), 41);

    // Back to 40, then a stalled taken branch.
    instr(7, 2, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 7, 3, 1, 0);
    check("s4_stall_pc", int'(pc), 40);
    instr(7, 3, 1, 0);
    check("s4_release_pc", int'(pc), 100);

    // Wrap at 1023, then a table write in RUN must be ignored.
    instr(7, 5, 1, 0);
    check("s5_top_pc", int'(pc), 1023);
    instr(0, 0, 0, 0);
    check("s5_wrap_pc", int'(pc), 0);
    cyc(0, 1, 2, 7, 0, 0, 0, 0, 0, 0);
    instr(5, 0, 0, 1);
    instr(7, 2, 1, 0);
    check("s5_table_kept", int'(pc), 40);

    // Halt, frozen PC, ignored stall/halt combo, restart from HALT.
    cyc(0, 0, 0, 0, 1, 1, 6, 7, 1, 0);
    instr(6, 7, 1, 0);
    check("s6_done", int'(done), 1);
    repeat (2) instr(0, 0, 0, 1);
    check("s6_frozen_pc", int'(pc), 40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) instr(0, 0, 0, 0);

    // Asynchronous reset mid-run.
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("mid");
    @(negedge clock);
    reset_n = 1'b1;

    // Start with simultaneous table write; earlier entries must be cleared.
    cyc(1, 1, 4, 77, 0, 0, 0, 0, 0, 0);
    instr(0, 0, 0, 0);
    instr(7, 4, 0, 0);
    check("s7_same_edge_pc", int'(pc), 77);
    instr(7, 2, 0, 0);
    check("s7_cleared_pc", int'(pc), 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      st_r = int'($urandom_range(0, 9));
      v_r  = int'($urandom_range(0, 9));
      op_r = int'($urandom_range(0, 11));
      if (op_r > 7) op_r = 7;
      if (m_mode == 1 && $urandom_range(0, 39) == 0) begin
        cyc(0, 0, 0, 0, 1, $urandom_range(0, 3) == 0, 6, 7, 1, 0);
      end else begin
        cyc(st_r < 2, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, PC_MOD - 1)), v_r < 8, v_r == 0,
            op_r, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      end
    end

    instr(0, 0, 0, 0);
    @(negedge clock);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
